// File: rtl/con_dump_if.sv
// Console read port plus dump stream for con_dump_ctrl.
// master = the dump controller, slave = memory/sink side.
interface con_dump_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [3:0]        con_write;
    logic [ADDR_W-1:0] con_addr;
    logic [DATA_W-1:0] con_out;
    logic              dout_valid;
    logic              dout_ready;
    logic [ADDR_W-1:0] dout_addr;
    logic [DATA_W-1:0] dout_data;

    modport master (
        output con_write, con_addr, dout_valid, dout_addr, dout_data,
        input  con_out, dout_ready
    );
    modport slave (
        input  con_write, con_addr, dout_valid, dout_addr, dout_data,
        output con_out, dout_ready
    );
endinterface

// File: rtl/con_dump_ctrl.sv
// Halt-loop detector and console memory dump sequencer for the RV32IMC core.
// Streams words 0..last_addr out as valid/ready beats once the program halts or on start.
module con_dump_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int IDLE_THRESH = 50,
    parameter int RD_LAT      = 1
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic [31:0]       if_inst,
    input  logic              start,
    input  logic [ADDR_W-1:0] last_addr,
    con_dump_if.master        bus,
    output logic              core_done,
    output logic [31:0]       cycle_count,
    output logic              busy,
    output logic              dump_done
);
    localparam int RUN_W = $clog2(IDLE_THRESH + 1);
    localparam int WC_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {WATCH, READ, WAIT, SEND, DONE} state_t;

    state_t            state;
    logic [31:0]       prev_inst;
    logic [RUN_W-1:0]  run, run_nxt;
    logic              done_hit;
    logic [ADDR_W-1:0] ptr, lim;
    logic [WC_W-1:0]   wcnt;

    always_comb begin
        run_nxt = '0;
        if (if_inst == prev_inst)
            run_nxt = (run == RUN_W'(IDLE_THRESH)) ? run : run + 1'b1;
    end
    // Stays true while the loop continues; only the first hit counts as a trigger.
    assign done_hit = (run_nxt == RUN_W'(IDLE_THRESH));

    always_ff @(posedge CLK) begin
        if (rst) begin
            prev_inst   <= '0;
            run         <= '0;
            core_done   <= 1'b0;
            cycle_count <= '0;
        end else begin
            prev_inst <= if_inst;
            run       <= run_nxt;
            if (done_hit)
                core_done <= 1'b1;
            if (!core_done && cycle_count != '1)
                cycle_count <= cycle_count + 1'b1;
        end
    end

    assign bus.con_write = 4'h0;

    always_ff @(posedge CLK) begin
        if (rst) begin
            state          <= WATCH;
            ptr            <= '0;
            lim            <= '0;
            wcnt           <= '0;
            bus.con_addr   <= '0;
            bus.dout_valid <= 1'b0;
            bus.dout_addr  <= '0;
            bus.dout_data  <= '0;
            busy           <= 1'b0;
            dump_done      <= 1'b0;
        end else begin
            case (state)
                WATCH: if ((done_hit && !core_done) || start) begin
                    ptr   <= '0;
                    lim   <= last_addr;
                    busy  <= 1'b1;
                    state <= READ;
                end
                READ: begin
                    bus.con_addr <= ptr;
                    wcnt         <= '0;
                    state        <= WAIT;
                end
                WAIT: begin
                    wcnt <= wcnt + 1'b1;
                    if (wcnt == WC_W'(RD_LAT - 1)) begin
                        bus.dout_data  <= bus.con_out;
                        bus.dout_addr  <= ptr;
                        bus.dout_valid <= 1'b1;
                        state          <= SEND;
                    end
                end
                SEND: if (bus.dout_ready) begin
                    bus.dout_valid <= 1'b0;
                    // Compare before increment so ptr never wraps on a full-range dump.
                    if (ptr == lim) begin
                        busy      <= 1'b0;
                        dump_done <= 1'b1;
                        state     <= DONE;
                    end else begin
                        ptr   <= ptr + 1'b1;
                        state <= READ;
                    end
                end
                DONE:    state <= DONE;
                default: state <= WATCH;
            endcase
        end
    end
endmodule

// File: tb/tb_con_dump_ctrl.sv
// Bench for con_dump_ctrl: table-driven dumps, halt-detect sequences, random stimulus vs a history model.
module tb_con_dump_ctrl;
    localparam int AW = 10, DW = 32, TH = 50, RL = 1;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [31:0]   if_inst = 32'h0;
    logic [AW-1:0] last_addr = '0;
    logic          core_done, busy, dump_done;
    logic [31:0]   cycle_count;

    con_dump_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
    logic [DW-1:0] mem [0:(1<<AW)-1];
    assign bus.con_out = mem[bus.con_addr];

    always #5 clk = ~clk;

    con_dump_ctrl #(.ADDR_W(AW), .DATA_W(DW), .IDLE_THRESH(TH), .RD_LAT(RL)) dut (
        .CLK(clk), .rst(rst), .if_inst(if_inst), .start(start), .last_addr(last_addr),
        .bus(bus.master), .core_done(core_done), .cycle_count(cycle_count),
        .busy(busy), .dump_done(dump_done));

    int n_cmp = 0, n_fail = 0, cyc = 0, cw_bad = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {int addr; logic [DW-1:0] data; int t;} beat_t;
    beat_t got[$];

    // Beat capture and backpressure stability monitor.
    logic hold_pend = 1'b0;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_data;
    always @(negedge clk) begin
        if (bus.con_write !== 4'h0) cw_bad++;
        if (!rst) begin
            if (hold_pend) begin
                chk("hold_valid", bus.dout_valid, 1);
                chk("hold_addr", bus.dout_addr, h_addr);
                chk("hold_data", bus.dout_data, h_data);
            end
            hold_pend = bus.dout_valid && !bus.dout_ready;
            h_addr = bus.dout_addr;
            h_data = bus.dout_data;
            if (bus.dout_valid && bus.dout_ready)
                got.push_back('{int'(bus.dout_addr), bus.dout_data, cyc});
        end else hold_pend = 1'b0;
    end

    // Halt model: history of sampled instructions since reset (entry 0 = cleared prev).
    logic [31:0] hist[$];
    bit mdone;
    int mcount;
    bit auto_inst = 1'b0;

    task automatic tick();
        logic [31:0] s = if_inst;
        logic r = rst;
        int n;
        bit all_eq;
        @(posedge clk); #1;
        if (r) begin
            hist.delete(); hist.push_back(32'h0); mdone = 0; mcount = 0;
        end else begin
            hist.push_back(s);
            if (!mdone) begin
                mcount++;
                n = hist.size() - 1;
                if (n >= TH) begin
                    all_eq = 1;
                    for (int j = 0; j < TH; j++)
                        if (hist[n-j] != hist[n-j-1]) all_eq = 0;
                    mdone = all_eq;
                end
            end
        end
        if (auto_inst) if_inst = if_inst + 1;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_con_addr"}, bus.con_addr, 0);
        chk({tag, "_valid"}, bus.dout_valid, 0);
        chk({tag, "_daddr"}, bus.dout_addr, 0);
        chk({tag, "_ddata"}, bus.dout_data, 0);
        chk({tag, "_core_done"}, core_done, 0);
        chk({tag, "_cycle_count"}, cycle_count, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_dump_done"}, dump_done, 0);
        chk({tag, "_con_write"}, bus.con_write, 0);
    endtask

    task automatic do_reset();
        rst = 1; start = 0; bus.dout_ready = 1;
        tick(); tick();
        rst = 0;
        got.delete();
    endtask

    task automatic run_dump(int lim, int sb, int sl, bit chg, bit rnd, int exp_n);
        int left = sl;
        int budget = 20 * (lim + 1) + 50;
        got.delete();
        last_addr = AW'(lim); bus.dout_ready = 1; start = 1;
        tick();
        start = 0;
        if (chg) last_addr = AW'(lim + 5);
        for (int k = 0; k < budget && !dump_done; k++) begin
            if (rnd) begin
                bus.dout_ready = ($urandom_range(0, 3) != 0);
                start = $urandom_range(0, 1);
            end else if (left > 0 && bus.dout_valid && int'(bus.dout_addr) == sb) begin
                bus.dout_ready = 0; left--;
            end else bus.dout_ready = 1;
            tick();
        end
        // Further starts after DONE must not produce more beats.
        bus.dout_ready = 1; start = 1;
        repeat (8) tick();
        start = 0;
        chk($sformatf("lim%0d_dump_done", lim), dump_done, 1);
        chk($sformatf("lim%0d_busy", lim), busy, 0);
        chk($sformatf("lim%0d_nbeats", lim), got.size(), exp_n);
        for (int i = 0; i < got.size() && i < exp_n; i++) begin
            chk($sformatf("lim%0d_b%0d_addr", lim, i), got[i].addr, i);
            chk($sformatf("lim%0d_b%0d_data", lim, i), got[i].data, mem[i]);
            if (!rnd && sl == 0 && i > 0)
                chk($sformatf("lim%0d_b%0d_gap", lim, i), got[i].t - got[i-1].t, RL + 2);
        end
    endtask

    typedef struct {int lim; int stall_beat; int stall_len; bit chg; int exp_n;} vec_t;
    vec_t vecs[5];

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        mem[0] = 32'h11111111; mem[1] = 32'h22222222;
        mem[2] = 32'h33333333; mem[3] = 32'h44444444;
        vecs[0] = '{3, -1, 0, 0, 4};
        vecs[1] = '{3, 1, 5, 0, 4};
        vecs[2] = '{0, -1, 0, 0, 1};
        vecs[3] = '{7, 2, 3, 1, 8};
        vecs[4] = '{1023, -1, 0, 0, 1024};

        // Reset state.
        bus.dout_ready = 1;
        rst = 1; tick();
        chk_zero("reset");
        do_reset();

        // Halt detect: distinct fetches for 20 cycles, then a held self-jump.
        last_addr = 0;
        for (int k = 1; k <= 20; k++) begin if_inst = k; tick(); end
        if_inst = 32'h0000006F;
        repeat (50) tick();
        chk("halt_early_done", core_done, 0);
        chk("halt_early_count", cycle_count, 70);
        tick();
        chk("halt_done", core_done, 1);
        chk("halt_count", cycle_count, 71);
        chk("halt_model_count", cycle_count, mcount);
        repeat (10) tick();
        chk("halt_frozen", cycle_count, 71);
        chk("halt_autodump_beats", got.size(), 1);
        chk("halt_autodump_done", dump_done, 1);

        // Near miss: 49 repeats, change, then 50 repeats.
        do_reset();
        if_inst = 32'h13;
        repeat (50) tick();
        chk("near_49", core_done, 0);
        if_inst = 32'h00000067;
        tick();
        chk("near_change", core_done, 0);
        repeat (49) tick();
        chk("near_99", core_done, 0);
        tick();
        chk("near_fire", core_done, 1);
        chk("near_count", cycle_count, 101);

        // Table-driven dumps.
        auto_inst = 1; if_inst = 32'h1000;
        foreach (vecs[v]) begin
            do_reset();
            run_dump(vecs[v].lim, vecs[v].stall_beat, vecs[v].stall_len, vecs[v].chg, 0, vecs[v].exp_n);
        end

        // Reset in the middle of a dump, at beat 2.
        do_reset();
        last_addr = 3; start = 1; tick(); start = 0;
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            if (bus.dout_valid && bus.dout_addr == 2) found = 1;
            else tick();
        end
        chk("mid_reach_beat2", found, 1);
        chk("mid_beats_before", got.size(), 2);
        rst = 1; tick();
        chk_zero("midrst");
        rst = 0; tick();
        chk("midrst_count", cycle_count, 1);
        chk("midrst_core_done", core_done, 0);
        repeat (3) tick();
        chk("midrst_no_beat", got.size(), 2);
        do_reset();
        run_dump(3, -1, 0, 0, 0, 4);

        // Random halt stimulus against the history model.
        auto_inst = 0;
        do_reset();
        last_addr = 2;
        for (int seg = 0; seg < 12; seg++) begin
            if_inst = $urandom_range(0, 3);
            repeat ($urandom_range(1, 70)) begin
                tick();
                chk("rnd_halt_done", core_done, mdone);
            end
        end
        chk("rnd_halt_count", cycle_count, mcount);

        // Random dumps with random ready and start noise.
        auto_inst = 1; if_inst = 32'h5000;
        for (int it = 0; it < 6; it++) begin
            int l = $urandom_range(0, 20);
            do_reset();
            run_dump(l, -1, 0, 0, 1, l + 1);
        end

        chk("con_write_never", cw_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
